store_ctrl: RTL and testbench

Store sequencer between the core's S-type decode and the data-memory port. It accepts store requests (funct3, byte address, register data) through a valid/ready handshake and buffers them in a small FIFO. It drains them to memory over a req/gnt bus as word-aligned accesses with byte enables, splitting misaligned SH/SW into two word accesses. It reports `busy` for core fencing and `st_fault` for rejected stores.

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/store_fifo.sv | 45 ++++
 rtl/store_ctrl.sv | 125 ++++++++++++
 tb/tb_store_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V encodings plus the store-path types and helpers
// used by store_ctrl and store_fifo.
package riscv_pkg;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } s_func;

    typedef enum logic [1:0] {
        IDLE,
        ACC1,
        ACC2
    } store_state_t;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] data;
    } store_entry_t;

    localparam int STORE_BUF_DEPTH = 2;

    // Byte enables across two adjacent words; bits [7:4] belong to the next word.
    // An all-zero result marks an illegal funct3.
    function automatic logic [7:0] store_mask8(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] base;
        case (funct3)
            SB:      base = 4'b0001;
            SH:      base = 4'b0011;
            SW:      base = 4'b1111;
            default: base = 4'b0000;
        endcase
        return {4'b0000, base} << off;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// store_fifo: DEPTH-entry store buffer holding {funct3, addr, data} in
// program order; head shows the oldest entry.
module store_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = STORE_BUF_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  store_entry_t wr_entry,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output store_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    store_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

endmodule

// File: rtl/store_ctrl.sv
// store_ctrl: buffers core stores and drains them as word-aligned memory accesses.
// Define STORE_MISALIGN_SPLIT_EN to split word-crossing SH/SW; otherwise they fault.
module store_ctrl
    import riscv_pkg::*;
#(
    parameter int DEPTH = STORE_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic        mem_gnt,
    output logic        busy,
    output logic        st_fault
);

    store_state_t state;
    store_state_t next_state;
    store_entry_t in_entry;
    store_entry_t head;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         st_legal;
    logic         head_split;
    logic [7:0]   in_mask8;
    logic [7:0]   head_mask8;
    logic [1:0]   head_off;
    logic [63:0]  head_data64;

    assign st_ready = !full && !reset;
    assign in_mask8 = store_mask8(st_funct3, st_addr[1:0]);

`ifdef STORE_MISALIGN_SPLIT_EN
    assign st_legal = (in_mask8 != 8'h00);
`else
    // Without splitting, anything reaching into the next word is refused.
    assign st_legal = (in_mask8[3:0] != 4'h0) && (in_mask8[7:4] == 4'h0);
`endif

    assign push     = st_valid && st_ready && st_legal;
    assign in_entry = '{funct3: st_funct3, addr: st_addr, data: st_data};

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wr_entry (in_entry),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    assign head_off    = head.addr[1:0];
    assign head_mask8  = store_mask8(head.funct3, head_off);
    assign head_data64 = {32'h0, head.data} << {head_off, 3'b000};
    assign head_split  = |head_mask8[7:4];

    assign mem_req = (state != IDLE);
    assign busy    = !empty || (state != IDLE);

    // NOTE: defaults first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: if (!empty) next_state = ACC1;
            ACC1: if (mem_gnt) begin
                if (head_split) begin
                    next_state = ACC2;
                end else begin
                    pop        = 1'b1;
                    next_state = IDLE;
                end
            end
            ACC2: if (mem_gnt) begin
                pop        = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= '0;
            st_fault  <= 1'b0;
        end else begin
            state    <= next_state;
            st_fault <= st_valid && st_ready && !st_legal;
            // Access outputs are loaded once per access and then held until granted.
            case (state)
                IDLE: if (!empty) begin
                    mem_addr  <= {head.addr[31:2], 2'b00};
                    mem_we    <= head_mask8[3:0];
                    mem_wdata <= head_data64[31:0];
                end
                ACC1: if (mem_gnt) begin
                    if (head_split) begin
                        mem_addr  <= {head.addr[31:2] + 30'd1, 2'b00};
                        mem_we    <= head_mask8[7:4];
                        mem_wdata <= head_data64[63:32];
                    end else begin
                        mem_we <= '0;
                    end
                end
                ACC2: if (mem_gnt) mem_we <= '0;
                default: mem_we <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_store_ctrl.sv
// tb_store_ctrl: directed self-checking bench for store_ctrl; expectations
// follow STORE_MISALIGN_SPLIT_EN when it is defined.
module tb_store_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_gnt;
    logic        busy;
    logic        st_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_ctrl #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_funct3 (st_funct3),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_gnt   (mem_gnt),
        .busy      (busy),
        .st_fault  (st_fault)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
        tick();
        st_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        st_valid  = 1'b0;
        mem_gnt   = 1'b0;
        st_funct3 = 3'b000;
        st_addr   = '0;
        st_data   = '0;
        tick();
        tick();
        checks++;
        if ({mem_req, mem_addr, mem_wdata, mem_we, st_fault, busy, st_ready} !== 72'h0) begin
            errors++;
            $display("FAIL reset_values got %h exp 0",
                     {mem_req, mem_addr, mem_wdata, mem_we, st_fault, busy, st_ready});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({st_ready, busy, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release got %b exp 100", {st_ready, busy, mem_req});
        end
    endtask

    task automatic test_sb();
        do_store(3'b000, 32'h0000_1001, 32'h0000_00AB);
        checks++;
        if ({mem_req, busy, st_fault} !== 3'b010) begin
            errors++;
            $display("FAIL sb_latency_n1 got %b exp 010", {mem_req, busy, st_fault});
        end
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'b0010, 32'h0000_1000, 32'h0000_AB00}) begin
            errors++;
            $display("FAIL sb_access got %h exp %h", {mem_req, mem_we, mem_addr, mem_wdata},
                     {1'b1, 4'b0010, 32'h0000_1000, 32'h0000_AB00});
        end
        mem_gnt = 1'b1;
        tick();
        checks++;
        if ({mem_req, mem_we, busy, st_fault} !== 7'b0) begin
            errors++;
            $display("FAIL sb_done got %b exp 0000000", {mem_req, mem_we, busy, st_fault});
        end
        mem_gnt = 1'b0;
    endtask

    task automatic test_sh_mid();
        mem_gnt = 1'b1;
        do_store(3'b001, 32'h0000_3001, 32'h1234_ABCD);
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'b0110, 32'h0000_3000, 32'h34AB_CD00}) begin
            errors++;
            $display("FAIL sh_mid_access got %h exp %h", {mem_req, mem_we, mem_addr, mem_wdata},
                     {1'b1, 4'b0110, 32'h0000_3000, 32'h34AB_CD00});
        end
        tick();
        checks++;
        if ({mem_req, busy, st_fault} !== 3'b000) begin
            errors++;
            $display("FAIL sh_mid_done got %b exp 000", {mem_req, busy, st_fault});
        end
        mem_gnt = 1'b0;
    endtask

    task automatic test_split();
        mem_gnt = 1'b0;
        do_store(3'b010, 32'h0000_2003, 32'h1122_3344);
`ifdef STORE_MISALIGN_SPLIT_EN
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'b1000, 32'h0000_2000, 32'h4400_0000}) begin
                errors++;
                $display("FAIL split_acc1_hold%0d got %h exp %h", i, {mem_req, mem_we, mem_addr, mem_wdata},
                         {1'b1, 4'b1000, 32'h0000_2000, 32'h4400_0000});
            end
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'b0111, 32'h0000_2004, 32'h0011_2233}) begin
            errors++;
            $display("FAIL split_acc2 got %h exp %h", {mem_req, mem_we, mem_addr, mem_wdata},
                     {1'b1, 4'b0111, 32'h0000_2004, 32'h0011_2233});
        end
        tick();
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL split_done got %b exp 00", {mem_req, busy});
        end
        mem_gnt = 1'b0;
`else
        checks++;
        if ({st_fault, busy, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL nosplit_fault got %b exp 100", {st_fault, busy, mem_req});
        end
        tick();
        checks++;
        if ({st_fault, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL nosplit_pulse got %b exp 00", {st_fault, mem_req});
        end
        tick();
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL nosplit_noreq got %b exp 00", {mem_req, busy});
        end
`endif
    endtask

    task automatic test_wrap();
        mem_gnt = 1'b1;
        do_store(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF);
`ifdef STORE_MISALIGN_SPLIT_EN
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'b1000, 32'hFFFF_FFFC, 32'hEF00_0000}) begin
            errors++;
            $display("FAIL wrap_acc1 got %h exp %h", {mem_req, mem_we, mem_addr, mem_wdata},
                     {1'b1, 4'b1000, 32'hFFFF_FFFC, 32'hEF00_0000});
        end
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'b0001, 32'h0000_0000, 32'h0000_00BE}) begin
            errors++;
            $display("FAIL wrap_acc2 got %h exp %h", {mem_req, mem_we, mem_addr, mem_wdata},
                     {1'b1, 4'b0001, 32'h0000_0000, 32'h0000_00BE});
        end
        tick();
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL wrap_done got %b exp 00", {mem_req, busy});
        end
`else
        checks++;
        if ({st_fault, busy} !== 2'b10) begin
            errors++;
            $display("FAIL wrap_fault got %b exp 10", {st_fault, busy});
        end
        tick();
        checks++;
        if ({st_fault, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL wrap_noreq got %b exp 00", {st_fault, mem_req});
        end
`endif
        mem_gnt = 1'b0;
    endtask

    task automatic test_back_to_back();
        mem_gnt   = 1'b0;
        st_valid  = 1'b1;
        st_funct3 = 3'b010;
        st_addr   = 32'h0000_0100;
        st_data   = 32'hA1A1_A1A1;
        checks++;
        if (st_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready0 got %b exp 1", st_ready);
        end
        tick();
        st_addr = 32'h0000_0104;
        st_data = 32'hB2B2_B2B2;
        checks++;
        if (st_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready1 got %b exp 1", st_ready);
        end
        tick();
        st_addr = 32'h0000_0108;
        st_data = 32'hC3C3_C3C3;
        checks++;
        if ({st_ready, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h0000_0100}) begin
            errors++;
            $display("FAIL b2b_full got %h exp %h", {st_ready, mem_req, mem_addr}, {1'b0, 1'b1, 32'h0000_0100});
        end
        tick();
        checks++;
        if ({st_ready, mem_req, mem_addr, mem_wdata} !== {1'b0, 1'b1, 32'h0000_0100, 32'hA1A1_A1A1}) begin
            errors++;
            $display("FAIL b2b_hold got %h exp %h", {st_ready, mem_req, mem_addr, mem_wdata},
                     {1'b0, 1'b1, 32'h0000_0100, 32'hA1A1_A1A1});
        end
        mem_gnt = 1'b1;
        tick();
        checks++;
        if ({st_ready, mem_req} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_ready_after_pop got %b exp 10", {st_ready, mem_req});
        end
        tick();
        st_valid = 1'b0;
        checks++;
        if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0104, 32'hB2B2_B2B2}) begin
            errors++;
            $display("FAIL b2b_second got %h exp %h", {mem_req, mem_addr, mem_wdata},
                     {1'b1, 32'h0000_0104, 32'hB2B2_B2B2});
        end
        tick();
        checks++;
        if ({mem_req, busy} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_gap got %b exp 01", {mem_req, busy});
        end
        tick();
        checks++;
        if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0108, 32'hC3C3_C3C3}) begin
            errors++;
            $display("FAIL b2b_third got %h exp %h", {mem_req, mem_addr, mem_wdata},
                     {1'b1, 32'h0000_0108, 32'hC3C3_C3C3});
        end
        tick();
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_busy_fall got %b exp 00", {mem_req, busy});
        end
        mem_gnt = 1'b0;
    endtask

    task automatic test_reset_illegal();
        mem_gnt   = 1'b0;
        st_valid  = 1'b1;
        st_funct3 = 3'b010;
`ifdef STORE_MISALIGN_SPLIT_EN
        st_addr   = 32'h0000_2003;
`else
        st_addr   = 32'h0000_2000;
`endif
        st_data   = 32'hCAFE_F00D;
        tick();
        st_addr = 32'h0000_3000;
        st_data = 32'h0000_0055;
        tick();
        st_valid = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++;
        if ({mem_req, mem_we} !== {1'b1, 4'b0111}) begin
            errors++;
            $display("FAIL rst_in_acc2 got %b exp 10111", {mem_req, mem_we});
        end
`else
        checks++;
        if ({mem_req, mem_we} !== {1'b1, 4'b1111}) begin
            errors++;
            $display("FAIL rst_in_acc1 got %b exp 11111", {mem_req, mem_we});
        end
`endif
        reset = 1'b1;
        tick();
        checks++;
        if ({mem_req, busy, st_ready, mem_we} !== 7'b0) begin
            errors++;
            $display("FAIL rst_abandon got %b exp 0000000", {mem_req, busy, st_ready, mem_we});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({mem_req, busy, st_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rst_release got %b exp 001", {mem_req, busy, st_ready});
        end
        tick();
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_discard got %b exp 00", {mem_req, busy});
        end
        do_store(3'b011, 32'h0000_4000, 32'h0000_0077);
        checks++;
        if ({st_fault, busy, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL illegal_fault got %b exp 100", {st_fault, busy, mem_req});
        end
        tick();
        checks++;
        if ({st_fault, busy, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL illegal_pulse got %b exp 000", {st_fault, busy, mem_req});
        end
        tick();
        tick();
        checks++;
        if ({mem_req, mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL illegal_noreq got %b exp 00000", {mem_req, mem_we});
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh_mid();
        test_split();
        test_wrap();
        test_back_to_back();
        test_reset_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
